// File: rtl/rot_sq_sched.sv
// Rotating-square scheduler: step/scan time bases, IDLE/RUN/PAUSED sequencing, 4-digit mux drive.
// Latency: all outputs registered; an/sseg show the scan index and pos of the previous cycle.
// Backpressure: none; pause freezes the step count while the display keeps scanning.
module rot_sq_sched #(
  parameter int STEP_DIV    = 50_000_000,
  parameter int REFRESH_DIV = 50_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       pause,
  input  logic       dir,
  output logic [2:0] pos,
  output logic       step_tick,
  output logic [6:0] sseg,
  output logic [3:0] an
);

  localparam int SW = $clog2(STEP_DIV);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);
  localparam logic [RW-1:0] SCAN_LAST = RW'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_UPPER = 7'b0011100;
  localparam logic [6:0] SEG_LOWER = 7'b0100011;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   step_cnt_q, step_cnt_d;
  logic [RW-1:0]   scan_cnt_q, scan_cnt_d;
  logic [1:0]      scan_idx_q, scan_idx_d;
  logic [2:0]      pos_q, pos_d;
  logic            step_tick_q, step_tick_d;
  logic [6:0]      sseg_q, sseg_d;
  logic [3:0]      an_q, an_d;
  logic [1:0]      lit_idx;

  // Next state, time-base counters, position stepping and registered display decode
  always_comb begin
    state_d     = IDLE;
    step_cnt_d  = step_cnt_q;
    scan_cnt_d  = scan_cnt_q;
    scan_idx_d  = scan_idx_q;
    pos_d       = pos_q;
    step_tick_d = 1'b0;
    an_d        = 4'b1111;
    sseg_d      = SEG_BLANK;
    // pos 0..3 light an[3..0] (upper), pos 4..7 light an[0..3] (lower)
    lit_idx     = pos_q[2] ? pos_q[1:0] : ~pos_q[1:0];

    if (en) begin
      state_d = pause ? PAUSED : RUN;
    end

    if (!en) begin
      // Leaving for IDLE discards every in-progress count
      step_cnt_d = '0;
      scan_cnt_d = '0;
      scan_idx_d = 2'd0;
      pos_d      = 3'd0;
    end else if (state_q != IDLE) begin
      // The enabling edge itself does not count, so the first tick lands STEP_DIV edges later.
      // Pause seen on the wrap cycle holds the counter at its last value; the wrap then
      // happens on the edge that resumes RUN.
      if (!pause) begin
        if (step_cnt_q == STEP_LAST) begin
          step_cnt_d  = '0;
          step_tick_d = 1'b1;
          pos_d       = dir ? pos_q - 3'd1 : pos_q + 3'd1;
        end else begin
          step_cnt_d = step_cnt_q + SW'(1);
        end
      end
      if (scan_cnt_q == SCAN_LAST) begin
        scan_cnt_d = '0;
        scan_idx_d = scan_idx_q + 2'd1;
      end else begin
        scan_cnt_d = scan_cnt_q + RW'(1);
      end
    end

    // Display follows last cycle's scan index and pos; blank while idle or dropping to idle
    if (en && state_q != IDLE) begin
      an_d = ~(4'b0001 << scan_idx_q);
      if (scan_idx_q == lit_idx) begin
        sseg_d = pos_q[2] ? SEG_LOWER : SEG_UPPER;
      end
    end
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      step_cnt_q  <= '0;
      scan_cnt_q  <= '0;
      scan_idx_q  <= 2'd0;
      pos_q       <= 3'd0;
      step_tick_q <= 1'b0;
      sseg_q      <= SEG_BLANK;
      an_q        <= 4'b1111;
    end else begin
      state_q     <= state_d;
      step_cnt_q  <= step_cnt_d;
      scan_cnt_q  <= scan_cnt_d;
      scan_idx_q  <= scan_idx_d;
      pos_q       <= pos_d;
      step_tick_q <= step_tick_d;
      sseg_q      <= sseg_d;
      an_q        <= an_d;
    end
  end

  assign pos       = pos_q;
  assign step_tick = step_tick_q;
  assign sseg      = sseg_q;
  assign an        = an_q;

endmodule

// File: tb/tb_rot_sq_sched.sv
// Bench for rot_sq_sched: behavioural model driven from spec rules, per-cycle compare, directed literals.
// Latency: model output is what the DUT must show after each rising edge.
// Backpressure: none.
module tb_rot_sq_sched;

  localparam int STEP_DIV    = 8;
  localparam int REFRESH_DIV = 2;

  logic       clk;
  logic       reset;
  logic       en;
  logic       pause;
  logic       dir;
  logic [2:0] pos;
  logic       step_tick;
  logic [6:0] sseg;
  logic [3:0] an;

  int n_cmp = 0;
  int n_err = 0;

  rot_sq_sched #(
    .STEP_DIV   (STEP_DIV),
    .REFRESH_DIV(REFRESH_DIV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .pause    (pause),
    .dir      (dir),
    .pos      (pos),
    .step_tick(step_tick),
    .sseg     (sseg),
    .an       (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Position map: which an bit is lit and which pattern it shows
  int         lit_bit [8] = '{3, 2, 1, 0, 0, 1, 2, 3};
  logic [6:0] lit_pat [8] = '{7'b0011100, 7'b0011100, 7'b0011100, 7'b0011100,
                              7'b0100011, 7'b0100011, 7'b0100011, 7'b0100011};

  // Model: mode 0 idle, 1 run, 2 paused; counts of counted run cycles and of lit cycles
  int         m_mode;
  int         m_run_cycles;
  int         m_lit_cycles;
  int         m_pos;
  logic       m_tick;
  logic [3:0] m_an;
  logic [6:0] m_sseg;
  int         tick_count;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode       = 0;
    m_run_cycles = 0;
    m_lit_cycles = 0;
    m_pos        = 0;
    m_tick       = 1'b0;
    m_an         = 4'b1111;
    m_sseg       = 7'b1111111;
  endtask

  // Applies the spec rules for one rising edge with the inputs currently on the pins
  task automatic model_edge();
    int digit;
    digit = (m_lit_cycles / REFRESH_DIV) % 4;
    if (en && m_mode != 0) begin
      m_an   = 4'b1111 & ~(4'b0001 << digit);
      m_sseg = (digit == lit_bit[m_pos]) ? lit_pat[m_pos] : 7'b1111111;
    end else begin
      m_an   = 4'b1111;
      m_sseg = 7'b1111111;
    end
    m_tick = 1'b0;
    if (!en) begin
      m_mode       = 0;
      m_run_cycles = 0;
      m_lit_cycles = 0;
      m_pos        = 0;
    end else begin
      if (m_mode != 0) begin
        m_lit_cycles = (m_lit_cycles + 1) % (4 * REFRESH_DIV);
        if (!pause) begin
          m_run_cycles = m_run_cycles + 1;
          if (m_run_cycles == STEP_DIV) begin
            m_run_cycles = 0;
            m_tick       = 1'b1;
            m_pos        = dir ? (m_pos + 7) % 8 : (m_pos + 1) % 8;
          end
        end
      end
      m_mode = pause ? 2 : 1;
    end
  endtask

  // One clock: drive inputs at the falling edge, advance model at the rising edge
  task automatic cycle(input logic e, input logic p, input logic d);
    en    = e;
    pause = p;
    dir   = d;
    @(posedge clk);
    model_edge();
    if (m_tick) tick_count++;
    @(negedge clk);
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    chk("pos", int'(pos), m_pos);
    chk("step_tick", int'(step_tick), int'(m_tick));
    chk("an", int'(an), int'(m_an));
    chk("sseg", int'(sseg), int'(m_sseg));
    chk("an_single_low", int'($countones(~an) <= 1), 1);
  end

  initial begin
    reset = 1'b0;
    en    = 1'b0;
    pause = 1'b0;
    dir   = 1'b0;
    model_reset();
    tick_count = 0;
    repeat (3) @(negedge clk);
    chk("reset_an", int'(an), 'hF);
    chk("reset_sseg", int'(sseg), 'h7F);
    chk("reset_pos", int'(pos), 0);
    chk("reset_tick", int'(step_tick), 0);
    reset = 1'b1;

    // Idle with en low: nothing moves
    repeat (100) cycle(1'b0, 1'b0, 1'b0);
    chk("idle_ticks", tick_count, 0);

    // Forward run: enabling edge t, then 80 edges
    tick_count = 0;
    cycle(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 80; k++) begin
      cycle(1'b1, 1'b0, 1'b0);
      if (k == 7) chk("fwd_no_early_tick", int'(step_tick), 0);
      if (k == 8) begin
        chk("fwd_first_tick", int'(step_tick), 1);
        chk("fwd_first_pos", int'(pos), 1);
      end
      if (k == 33) begin
        chk("fwd_pos4_an", int'(an), 'b1110);
        chk("fwd_pos4_sseg", int'(sseg), 'b0100011);
      end
      if (k == 64) chk("fwd_wrap_pos", int'(pos), 0);
      if (k == 71) begin
        chk("fwd_pos0_an", int'(an), 'b0111);
        chk("fwd_pos0_sseg", int'(sseg), 'b0011100);
      end
    end
    chk("fwd_tick_count", tick_count, 10);
    chk("fwd_final_pos", int'(pos), 2);

    // Reverse wrap from pos 0, then dir toggled mid-interval
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      cycle(1'b1, 1'b0, (k >= 12 && k <= 14) || k == 16 ? 1'b0 : 1'b1);
      if (k == 8) chk("rev_wrap_pos", int'(pos), 7);
      if (k == 12) chk("rev_toggle_hold", int'(pos), 7);
      if (k == 16) chk("rev_toggle_next", int'(pos), 0);
    end

    // Pause asserted on the wrap cycle, then resumed
    repeat (7) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    chk("pause_no_tick", int'(step_tick), 0);
    chk("pause_pos", int'(pos), 0);
    tick_count = 0;
    repeat (8) cycle(1'b1, 1'b1, 1'b0);
    chk("pause_ticks", tick_count, 0);
    cycle(1'b1, 1'b0, 1'b0);
    chk("resume_tick", int'(step_tick), 1);
    chk("resume_pos", int'(pos), 1);

    // en low wins over pause; re-enable paused keeps pos at 0
    repeat (2) cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    chk("prio_an", int'(an), 'hF);
    chk("prio_sseg", int'(sseg), 'h7F);
    chk("prio_pos", int'(pos), 0);
    tick_count = 0;
    for (int k = 1; k <= 10; k++) begin
      cycle(1'b1, 1'b1, 1'b0);
      if (k == 2) chk("reen_paused_an", int'(an), 'b1110);
    end
    chk("reen_paused_pos", int'(pos), 0);
    chk("reen_paused_ticks", tick_count, 0);

    // Randomized operation
    begin
      logic e, p, d;
      e = 1'b1;
      p = 1'b0;
      d = 1'b0;
      for (int k = 0; k < 3000; k++) begin
        if ($urandom_range(0, 39) == 0) e = ~e;
        if ($urandom_range(0, 11) == 0) p = ~p;
        if ($urandom_range(0, 6) == 0) d = ~d;
        cycle(e, p, d);
      end
    end

    // Asynchronous reset between edges while running
    repeat (20) cycle(1'b1, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("areset_an", int'(an), 'hF);
    chk("areset_sseg", int'(sseg), 'h7F);
    chk("areset_pos", int'(pos), 0);
    chk("areset_tick", int'(step_tick), 0);
    @(negedge clk);
    reset = 1'b1;
    tick_count = 0;
    cycle(1'b1, 1'b0, 1'b0);
    repeat (8) cycle(1'b1, 1'b0, 1'b0);
    chk("post_reset_first_tick", int'(step_tick), 1);
    chk("post_reset_ticks", tick_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
